// File: rtl/oq_regs_access_arb.sv
// Output-queue register access arbiter: serializes host accesses and
// enq/deq counter read-modify-write updates onto a single register RAM port.
module oq_regs_access_arb #(
   parameter int NUM_OQ_WIDTH = 3,
   parameter int ADDR_WIDTH   = 5,
   parameter int DELTA_WIDTH  = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           host_req,
   input  logic                           host_rd_wr_L,
   input  logic [ADDR_WIDTH-1:0]          host_addr,
   input  logic [NUM_OQ_WIDTH-1:0]        host_q,
   input  logic [31:0]                    host_wr_data,
   output logic                           host_result_ready,
   output logic [31:0]                    host_result,
   input  logic                           enq_upd_req,
   input  logic [NUM_OQ_WIDTH-1:0]        enq_upd_q,
   input  logic [ADDR_WIDTH-1:0]          enq_upd_addr,
   input  logic [DELTA_WIDTH-1:0]         enq_upd_delta,
   output logic                           enq_upd_ack,
   input  logic                           deq_upd_req,
   input  logic [NUM_OQ_WIDTH-1:0]        deq_upd_q,
   input  logic [ADDR_WIDTH-1:0]          deq_upd_addr,
   input  logic [DELTA_WIDTH-1:0]         deq_upd_delta,
   output logic                           deq_upd_ack,
   output logic [NUM_OQ_WIDTH+ADDR_WIDTH-1:0] ram_addr,
   output logic                           ram_rd_en,
   output logic                           ram_wr_en,
   output logic [31:0]                    ram_wr_data,
   input  logic [31:0]                    ram_rd_data
);

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;
   typedef enum logic [1:0] {P_HOST, P_ENQ, P_DEQ} port_t;

   state_t                   state, state_nxt;
   port_t                    port;
   logic [NUM_OQ_WIDTH-1:0]  lq;
   logic [ADDR_WIDTH-1:0]    laddr;
   logic [31:0]              ldata;
   logic [31:0]              cap;
   logic                     enq_next;
   logic [2:0]               starve_cnt;
   logic                     gnt_host, gnt_enq, gnt_deq;
   logic [32:0]              sum;
   logic [31:0]              wr_val;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      gnt_host  = 1'b0;
      gnt_enq   = 1'b0;
      gnt_deq   = 1'b0;
      state_nxt = state;
      if (state == IDLE) begin
         // host forced in once updates have held it off four times
         if (host_req && starve_cnt == 3'd4) begin
            gnt_host = 1'b1;
         end else if (enq_upd_req && deq_upd_req) begin
            gnt_enq = enq_next;
            gnt_deq = !enq_next;
         end else if (enq_upd_req) begin
            gnt_enq = 1'b1;
         end else if (deq_upd_req) begin
            gnt_deq = 1'b1;
         end else if (host_req) begin
            gnt_host = 1'b1;
         end
      end
      unique case (state)
         IDLE: begin
            if (gnt_host)
               state_nxt = host_rd_wr_L ? RD : WR;
            else if (gnt_enq || gnt_deq)
               state_nxt = RD;
         end
         RD:      state_nxt = CAP;
         CAP:     state_nxt = (port == P_HOST) ? DONE : WR;
         WR:      state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign sum = {1'b0, cap} + {1'b0, ldata};

   always_comb begin
      wr_val = 32'h0;
      unique case (port)
         P_HOST:  wr_val = ldata;
         P_ENQ:   wr_val = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
         P_DEQ:   wr_val = (cap < ldata) ? 32'h0 : cap - ldata;
         default: wr_val = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         port        <= P_HOST;
         lq          <= '0;
         laddr       <= '0;
         ldata       <= '0;
         cap         <= '0;
         enq_next    <= 1'b1;
         starve_cnt  <= '0;
         host_result <= '0;
      end else begin
         if (gnt_host) begin
            port       <= P_HOST;
            lq         <= host_q;
            laddr      <= host_addr;
            ldata      <= host_wr_data;
            starve_cnt <= '0;
         end
         if (gnt_enq) begin
            port     <= P_ENQ;
            lq       <= enq_upd_q;
            laddr    <= enq_upd_addr;
            ldata    <= 32'(enq_upd_delta);
            enq_next <= 1'b0;
         end
         if (gnt_deq) begin
            port     <= P_DEQ;
            lq       <= deq_upd_q;
            laddr    <= deq_upd_addr;
            ldata    <= 32'(deq_upd_delta);
            enq_next <= 1'b1;
         end
         if (gnt_enq || gnt_deq)
            starve_cnt <= host_req ? starve_cnt + 3'd1 : 3'd0;
         if (state == CAP) begin
            cap <= ram_rd_data;
            if (port == P_HOST) host_result <= ram_rd_data;
         end
         if (state == WR && port == P_HOST)
            host_result <= ldata;
      end
   end

   assign ram_addr          = {lq, laddr};
   assign ram_rd_en         = (state == RD);
   assign ram_wr_en         = (state == WR);
   assign ram_wr_data       = (state == WR) ? wr_val : 32'h0;
   assign host_result_ready = (state == DONE) && (port == P_HOST);
   assign enq_upd_ack       = (state == DONE) && (port == P_ENQ);
   assign deq_upd_ack       = (state == DONE) && (port == P_DEQ);

endmodule

// File: tb/tb_oq_regs_access_arb.sv
// Directed bench for oq_regs_access_arb with a behavioural register RAM.
module tb_oq_regs_access_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic        host_req = 0, host_rd_wr_L = 0;
   logic [4:0]  host_addr = 0;
   logic [2:0]  host_q = 0;
   logic [31:0] host_wr_data = 0;
   logic        host_result_ready;
   logic [31:0] host_result;
   logic        enq_upd_req = 0, deq_upd_req = 0;
   logic [2:0]  enq_upd_q = 0, deq_upd_q = 0;
   logic [4:0]  enq_upd_addr = 0, deq_upd_addr = 0;
   logic [15:0] enq_upd_delta = 0, deq_upd_delta = 0;
   logic        enq_upd_ack, deq_upd_ack;
   logic [7:0]  ram_addr;
   logic        ram_rd_en, ram_wr_en;
   logic [31:0] ram_wr_data;
   logic [31:0] ram_rd_data = 0;

   logic [31:0] mem [256];
   logic        pre_we = 0;
   logic [7:0]  pre_addr = 0;
   logic [31:0] pre_data = 0;

   int pass = 0, total = 0, overlap = 0;

   oq_regs_access_arb dut (
      .clk(clk), .reset(reset),
      .host_req(host_req), .host_rd_wr_L(host_rd_wr_L),
      .host_addr(host_addr), .host_q(host_q),
      .host_wr_data(host_wr_data),
      .host_result_ready(host_result_ready), .host_result(host_result),
      .enq_upd_req(enq_upd_req), .enq_upd_q(enq_upd_q),
      .enq_upd_addr(enq_upd_addr), .enq_upd_delta(enq_upd_delta),
      .enq_upd_ack(enq_upd_ack),
      .deq_upd_req(deq_upd_req), .deq_upd_q(deq_upd_q),
      .deq_upd_addr(deq_upd_addr), .deq_upd_delta(deq_upd_delta),
      .deq_upd_ack(deq_upd_ack),
      .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
      .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
      if (ram_rd_en) ram_rd_data <= mem[ram_addr];
   end

   always @(negedge clk)
      if (ram_rd_en && ram_wr_en) overlap++;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic poke(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      pre_we = 1; pre_addr = a; pre_data = d;
      @(negedge clk);
      pre_we = 0;
   endtask

   // kind: 0 host read, 1 host write, 2 enq update, 3 deq update
   task automatic run_txn(input int kind, input logic [2:0] q,
                          input logic [4:0] a, input logic [31:0] arg,
                          output int lat, output int rd_at,
                          output int wr_at, output int npulse,
                          output logic [31:0] res,
                          output logic [7:0] waddr);
      lat = -1; rd_at = -1; wr_at = -1; npulse = 0;
      res = 0; waddr = 0;
      @(negedge clk);
      case (kind)
         0, 1: begin
            host_req = 1; host_rd_wr_L = (kind == 0);
            host_q = q; host_addr = a; host_wr_data = arg;
         end
         2: begin
            enq_upd_req = 1; enq_upd_q = q;
            enq_upd_addr = a; enq_upd_delta = arg[15:0];
         end
         default: begin
            deq_upd_req = 1; deq_upd_q = q;
            deq_upd_addr = a; deq_upd_delta = arg[15:0];
         end
      endcase
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (ram_rd_en && rd_at < 0) rd_at = n;
         if (ram_wr_en && wr_at < 0) begin
            wr_at = n; waddr = ram_addr;
         end
         npulse += int'(host_result_ready) + int'(enq_upd_ack)
                 + int'(deq_upd_ack);
         if (lat < 0 && ((kind < 2 && host_result_ready) ||
             (kind == 2 && enq_upd_ack) || (kind == 3 && deq_upd_ack))) begin
            lat = n; res = host_result;
            host_req = 0; enq_upd_req = 0; deq_upd_req = 0;
         end
      end
      host_req = 0; enq_upd_req = 0; deq_upd_req = 0;
   endtask

   typedef struct {
      int          kind;
      logic [2:0]  q;
      logic [4:0]  a;
      logic [31:0] arg;
      logic [31:0] init;
      int          lat;
      logic [31:0] res;
      logic [31:0] ram;
   } vec_t;

   vec_t tbl [9];

   initial begin
      int lat, rd_at, wr_at, np, ea, da, hr, ua, na;
      logic [31:0] res;
      logic [7:0]  wa;
      logic        seen;

      tbl[0] = '{0, 3'd3, 5'd2,  32'h0,         32'h10,        3, 32'h10,        32'h10};
      tbl[1] = '{1, 3'd7, 5'd31, 32'hDEAD_BEEF, 32'h0,         2, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      tbl[2] = '{2, 3'd1, 5'd4,  32'd5,         32'd100,       4, 32'h0,         32'd105};
      tbl[3] = '{3, 3'd1, 5'd4,  32'd3,         32'd100,       4, 32'h0,         32'd97};
      tbl[4] = '{2, 3'd2, 5'd0,  32'd4,         32'hFFFF_FFFE, 4, 32'h0,         32'hFFFF_FFFF};
      tbl[5] = '{3, 3'd5, 5'd9,  32'd7,         32'd2,         4, 32'h0,         32'h0};
      tbl[6] = '{2, 3'd0, 5'd0,  32'hFFFF,      32'hFFFF_0000, 4, 32'h0,         32'hFFFF_FFFF};
      tbl[7] = '{3, 3'd6, 5'd3,  32'd7,         32'd7,         4, 32'h0,         32'h0};
      tbl[8] = '{0, 3'd0, 5'd1,  32'h0,         32'h0000_A5A5, 3, 32'h0000_A5A5, 32'h0000_A5A5};

      reset = 0;
      repeat (2) @(negedge clk);
      chk("rst_rd_en", 32'(ram_rd_en), 0);
      chk("rst_wr_en", 32'(ram_wr_en), 0);
      chk("rst_pulses", 32'({host_result_ready, enq_upd_ack, deq_upd_ack}), 0);
      chk("rst_result", host_result, 0);
      chk("rst_addr", 32'(ram_addr), 0);
      chk("rst_wdata", ram_wr_data, 0);
      reset = 1;

      foreach (tbl[i]) begin
         poke({tbl[i].q, tbl[i].a}, tbl[i].init);
         run_txn(tbl[i].kind, tbl[i].q, tbl[i].a, tbl[i].arg,
                 lat, rd_at, wr_at, np, res, wa);
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
         chk($sformatf("v%0d_pulses", i), 32'(np), 1);
         chk($sformatf("v%0d_rd_at", i), 32'(rd_at),
             tbl[i].kind == 1 ? 32'hFFFF_FFFF : 32'd1);
         chk($sformatf("v%0d_wr_at", i), 32'(wr_at),
             tbl[i].kind == 0 ? 32'hFFFF_FFFF :
             tbl[i].kind == 1 ? 32'd1 : 32'd3);
         if (tbl[i].kind != 0)
            chk($sformatf("v%0d_waddr", i), 32'(wa), 32'({tbl[i].q, tbl[i].a}));
         if (tbl[i].kind < 2)
            chk($sformatf("v%0d_result", i), res, tbl[i].res);
         chk($sformatf("v%0d_ram", i), mem[{tbl[i].q, tbl[i].a}], tbl[i].ram);
      end

      // both update ports hit the same counter together
      poke(8'h4C, 32'd100);
      @(negedge clk);
      enq_upd_req = 1; enq_upd_q = 3'd2; enq_upd_addr = 5'd12; enq_upd_delta = 16'd5;
      deq_upd_req = 1; deq_upd_q = 3'd2; deq_upd_addr = 5'd12; deq_upd_delta = 16'd3;
      ea = -1; da = -1;
      for (int n = 1; n <= 15; n++) begin
         @(negedge clk);
         if (enq_upd_ack && ea < 0) begin ea = n; enq_upd_req = 0; end
         if (deq_upd_ack && da < 0) begin da = n; deq_upd_req = 0; end
      end
      enq_upd_req = 0; deq_upd_req = 0;
      chk("rr_enq_ack", 32'(ea), 4);
      chk("rr_deq_ack", 32'(da), 9);
      chk("rr_final", mem[8'h4C], 32'd102);

      // host held off by continuous updates
      poke(8'h81, 32'h1234);
      poke(8'h85, 32'd0);
      poke(8'h86, 32'd10);
      @(negedge clk);
      host_req = 1; host_rd_wr_L = 1; host_q = 3'd4; host_addr = 5'd1;
      enq_upd_req = 1; enq_upd_q = 3'd4; enq_upd_addr = 5'd5; enq_upd_delta = 16'd1;
      deq_upd_req = 1; deq_upd_q = 3'd4; deq_upd_addr = 5'd6; deq_upd_delta = 16'd1;
      hr = -1; ua = 0; res = 0;
      for (int n = 1; n <= 40 && hr < 0; n++) begin
         @(negedge clk);
         ua += int'(enq_upd_ack) + int'(deq_upd_ack);
         if (host_result_ready) begin
            hr = n; res = host_result;
            host_req = 0; enq_upd_req = 0; deq_upd_req = 0;
         end
      end
      host_req = 0; enq_upd_req = 0; deq_upd_req = 0;
      repeat (3) @(negedge clk);
      chk("starve_ready_at", 32'(hr), 23);
      chk("starve_upd_acks", 32'(ua), 4);
      chk("starve_result", res, 32'h1234);
      chk("starve_enq_ram", mem[8'h85], 32'd2);
      chk("starve_deq_ram", mem[8'h86], 32'd8);

      // reset during the write phase of an update
      poke(8'h47, 32'd50);
      @(negedge clk);
      enq_upd_req = 1; enq_upd_q = 3'd2; enq_upd_addr = 5'd7; enq_upd_delta = 16'd9;
      seen = 0;
      for (int n = 1; n <= 10 && !seen; n++) begin
         @(negedge clk);
         if (ram_wr_en) seen = 1;
      end
      chk("mid_wr_seen", 32'(seen), 1);
      reset = 0;
      enq_upd_req = 0;
      #1;
      chk("mid_wr_drop", 32'(ram_wr_en), 0);
      chk("mid_ack_low", 32'(enq_upd_ack), 0);
      @(negedge clk);
      reset = 1;
      na = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         na += int'(enq_upd_ack) + int'(ram_wr_en) + int'(ram_rd_en);
      end
      chk("mid_no_activity", 32'(na), 0);
      chk("mid_ram_kept", mem[8'h47], 32'd50);
      run_txn(0, 3'd2, 5'd7, 32'h0, lat, rd_at, wr_at, np, res, wa);
      chk("post_rst_lat", 32'(lat), 3);
      chk("post_rst_result", res, 32'd50);

      chk("rd_wr_overlap", 32'(overlap), 0);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule

// File: doc/oq_regs_access_arb.md
OQ_REGS_ACCESS_ARB -- requirements
Module: oq_regs_access_arb

Interface
REQ-001 Parameter NUM_OQ_WIDTH, default 3: queue-number width (8 output queues).
REQ-002 Parameter ADDR_WIDTH, default 5: per-queue register-number width (up to 32 registers per queue).
REQ-003 Parameter DELTA_WIDTH, default 16: width of counter update amounts.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset; reset asserted when low.
REQ-006 host_req  in  1  host access pending (level); driven by the host register interface's req_in_progress.
REQ-007 host_rd_wr_L  in  1  1 = read, 0 = write.
REQ-008 host_addr  in  ADDR_WIDTH  register number; host_q  in  NUM_OQ_WIDTH  queue number.
REQ-009 host_wr_data  in  32  host write data.
REQ-010 host_result_ready  out  1  one-cycle completion pulse; host_result  out  32  read data, or written data for writes.
REQ-011 enq_upd_req / deq_upd_req  in  1 each  counter-update request (level, held until ack).
REQ-012 enq_upd_q / deq_upd_q  in  NUM_OQ_WIDTH; enq_upd_addr / deq_upd_addr  in  ADDR_WIDTH; enq_upd_delta / deq_upd_delta  in  DELTA_WIDTH.
REQ-013 enq_upd_ack / deq_upd_ack  out  1 each  one-cycle completion pulse.
REQ-014 ram_addr  out  NUM_OQ_WIDTH+ADDR_WIDTH  {queue, register}; ram_rd_en  out  1; ram_wr_en  out  1; ram_wr_data  out  32; ram_rd_data  in  32, valid exactly one cycle after ram_rd_en.

Function
REQ-015 Exactly one access in flight; RAM port owned by the current grant only.
REQ-016 FSM states: IDLE, RD, CAP, WR, DONE.
REQ-017 IDLE with no request: stay IDLE. With a request: latch winner's port ID, queue, address, data/delta, direction; next state RD, or WR for a host write.
REQ-018 RD: ram_rd_en=1, ram_addr = latched {q,addr}; next CAP.
REQ-019 CAP: capture ram_rd_data; host read -> DONE; update -> WR.
REQ-020 WR: ram_wr_en=1, same ram_addr; host write -> ram_wr_data = latched host_wr_data; next DONE.
REQ-021 Enq update write value = captured + zero-extended delta, saturating at 32'hFFFF_FFFF.
REQ-022 Deq update write value = captured - zero-extended delta, floored at 0.
REQ-023 DONE: pulse exactly one of host_result_ready / enq_upd_ack / deq_upd_ack for the latched port; next IDLE.
REQ-024 host_result updates only in DONE of a host access: captured data for reads, written data for writes; holds otherwise.
REQ-025 Requests are sampled only in IDLE; requesters drop req on the edge that samples ack/ready.
REQ-026 Latency from IDLE-cycle grant: host read ready at +3, host write ready at +2, update ack at +4.
REQ-027 Priority: updates over host; enq vs deq alternate round-robin, with the last-granted update port losing a tie.
REQ-028 Starvation guard: count consecutive update grants while host_req=1; at 4, the next IDLE grant goes to host and the counter clears; the counter also clears on any host grant.
REQ-029 ram_rd_en, ram_wr_en and the ack/ready pulses decode only from the registered state; they are never asserted together.
REQ-030 Same-address updates from both ports are serialized, so no increment or decrement is lost.

Reset
REQ-031 While reset is low: state=IDLE, all outputs 0, latched fields 0, round-robin pointer = enq next, starvation counter 0.
REQ-032 Reset mid-access abandons the access: no RAM write and no ack/ready pulse afterwards.
REQ-033 First grant is possible in the first IDLE cycle after reset deasserts.

Verification
REQ-034 RAM[q3,r2]=0x10, host read q3/r2 -> ram_rd_en at +1, host_result_ready with host_result=0x10 at +3, single pulse.
REQ-035 enq_upd and deq_upd both raised, same address, RAM=100, deltas 5 and 3 -> enq served first, deq second, final 102, two acks 5 cycles apart.
REQ-036 RAM=0xFFFF_FFFE, enq delta 4 -> 0xFFFF_FFFF; RAM=2, deq delta 7 -> 0.
REQ-037 host_req held while both update ports request continuously -> host granted after the 4th update grant; its result is correct.
REQ-038 Reset pulled low during WR of an update -> ram_wr_en drops immediately, no ack, FSM in IDLE, RAM unchanged.
REQ-039 Host write 0xDEAD_BEEF to q7/r31 -> ram_wr_en at +1 with ram_addr=0xFF; host_result=0xDEAD_BEEF with ready at +2.
